frame_buffer: RTL and testbench
===============================

# frame_buffer

Store-and-forward frame buffer directly downstream of the marker-delimited input deframer. It accepts the deframer's payload stream (`idata`/`ivalid`, with `ivalid` low between frames), holds each frame until its last word has arrived, then replays it with a valid/ready handshake and an end-of-frame flag. Frames that cannot fit are dropped whole, so downstream logic only ever sees complete frames.

## Interface
- `w`, 128: word width; multiple of 16, matching the deframer.
- `DEPTH`, 64: buffer capacity in words; power of two, ≥ 4.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; all state cleared while low.
- `idata` in [0:w-1]: payload word from the deframer.
- `ivalid` in 1: high for each payload word; a 1→0 transition ends a frame.
- `odata` out [0:w-1]: buffered word; reset 0.
- `ovalid` out 1: `odata` holds a committed word; reset 0.
- `olast` out 1: qualifies `odata` as the final word of its frame; reset 0.
- `iready` in 1: downstream accepts the word when `ovalid && iready` at a rising edge.
- `odrop` out 1: one-cycle pulse when a frame is discarded; reset 0.

## Operation
- Circular buffer uses three pointers of log2(DEPTH)+1 bits: `wr` (next write), `cm` (commit boundary) and `rd` (next read). Occupancy is `wr - rd`, modulo 2^(AW+1).
- Write side:
  - A word is written at `wr` on each edge with `ivalid=1`, unless the current frame is marked bad.
  - A word arriving with occupancy == DEPTH marks the frame bad and is discarded. All further words of that frame are also discarded.
- Frame end is an edge where `ivalid=0` and the previous sampled `ivalid=1`.
  - Good frame: `cm <= wr`, and the last-flag bit at address `wr-1` is set.
  - Bad frame: `wr <= cm` (rollback), `odrop` pulses for one cycle, and the bad mark clears.
- Last-flag bits are cleared at write time, so every non-final word carries `olast=0`.
- Read side uses a registered output stage. It loads from `rd` when (`ovalid=0` or the current word is being accepted) and `rd != cm`; loading increments `rd`.
- `odata`/`olast` stay stable while `ovalid && !iready`.
- Words are never read past `cm`: uncommitted data stays invisible.
- A frame longer than DEPTH is always dropped.
- A frame may start on the cycle immediately after the previous frame ends. The deframer guarantees at least one `ivalid=0` cycle between frames.

## Timing
- Commit happens at the frame-end edge E. Taking the buffer as empty and `ovalid=0` beforehand, the first word appears with `ovalid=1` after edge E+1.
- Back-to-back output throughput is one word per cycle while `iready=1` and committed data exists. There are no bubbles between frames.
- A word is written, a word is read and a commit occur together in one cycle without conflict. A commit at edge E is visible to the read side from edge E+1.
- Full plus a simultaneous read: occupancy is sampled before the read, so the incoming word is still treated as overflow. Flagging the frame bad on this conservative test is intended.
- `odrop` is asserted for the single cycle after the frame-end edge of a bad frame.
- When `reset` goes low mid-frame or mid-drain:
  - pointers, bad mark, the last-flag array and all outputs clear immediately;
  - partial and committed frames are lost;
  - the first `ivalid=1` sample after release starts a new frame.

## Configuration
- `FRAME_BUFFER_DROP_CNT_EN` defined:
  - adds output `drop_count` [15:0], reset 0;
  - increments on every `odrop` pulse;
  - saturates at 16'hFFFF.
- Not defined: the port and counter are absent, and `odrop` is the only drop indication.

## Structure
- Shared package `frame_buffer_pkg` holds:
  - the `ptr_t` typedef (AW+1 bits) and an occupancy helper function;
  - the `DROP_CNT_W = 16` constant.
- Sub-module `frame_buffer_ram` is a simple dual-port memory of DEPTH × (w+1) bits, holding data plus the last flag. It has one write port, plus a separate flag-set port used at commit, and one synchronous read port.
- Pointer control, bad-frame tracking and the output register live in `frame_buffer`.

## Test plan
- **Single frame:** 3 words A, B, C with `ivalid` high, then low, `iready=1` → A, B, C on consecutive cycles with `olast` only on C. First `ovalid` appears 2 edges after the `ivalid`-low edge.
- **Back-to-back frames:** frames of 2 and 5 words with one idle cycle between them, `iready=1` → 7 words in order with no gap, and `olast` on word 2 and word 7.
- **Backpressure:** `iready=0` for 10 cycles during drain → `odata`/`olast` held constant; no word lost or duplicated after `iready` returns to 1.
- **Overflow:** with DEPTH=64, send a 70-word frame while `iready=0` → `odrop` pulses once, `ovalid` stays 0, `wr` equals its pre-frame value. A following 4-word frame drains intact.
- **Reset mid-frame:** assert `reset=0` after 3 words of a frame and after one committed frame → all outputs 0 immediately; nothing is emitted after release until a new complete frame arrives.
- **`FRAME_BUFFER_DROP_CNT_EN`:** three oversized frames → `drop_count` = 3. Preload the counter to 16'hFFFF and cause one more drop → it stays 16'hFFFF.

Source files
------------

// File: rtl/frame_buffer_pkg.sv
// frame_buffer_pkg: shared pointer type, occupancy helper and drop-counter width.
package frame_buffer_pkg;
  localparam int FB_DEPTH   = 64;
  localparam int FB_AW      = $clog2(FB_DEPTH);
  localparam int DROP_CNT_W = 16;

  // Pointers carry one wrap bit above the address so full and empty differ.
  typedef logic [FB_AW:0] ptr_t;

  // Words held between the write and read pointers (modulo pointer width).
  function automatic ptr_t occupancy(input ptr_t wr, input ptr_t rd);
    return wr - rd;
  endfunction
endpackage

// File: rtl/frame_buffer_ram.sv
// frame_buffer_ram: DEPTH x (W+1) dual-port store. Data plus a per-word last
// flag; the flag has its own set port so a commit can mark the final word
// without rewriting it. Read port is registered and holds when not enabled.
module frame_buffer_ram #(
  parameter int W     = 128,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [0:W-1]  i_wdata,
  input  logic          i_fset,
  input  logic [AW-1:0] i_faddr,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [0:W-1]  o_rdata,
  output logic          o_rlast
);
  logic [0:W-1]     r_mem [DEPTH];
  logic [DEPTH-1:0] r_flag;
  logic [0:W-1]     r_rdata;
  logic             r_rlast;

  // Data array: plain write port, no reset needed.
  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Last flags: cleared on every write, set at commit for the final word.
  // Both never target the same address in one cycle (no write at frame end).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_flag <= '0;
    end else begin
      if (i_we)   r_flag[i_waddr] <= 1'b0;
      if (i_fset) r_flag[i_faddr] <= 1'b1;
    end
  end

  // Registered read; this register is the block's output stage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rdata <= '0;
      r_rlast <= 1'b0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
      r_rlast <= r_flag[i_raddr];
    end
  end

  assign o_rdata = r_rdata;
  assign o_rlast = r_rlast;
endmodule

// File: rtl/frame_buffer.sv
// frame_buffer: store-and-forward buffer behind the input deframer. Frames are
// released only after their last word lands; frames that overflow are dropped
// whole. Optional FRAME_BUFFER_DROP_CNT_EN adds a saturating drop_count output.
// Pointers use ptr_t, so DEPTH must equal FB_DEPTH from the package.
module frame_buffer
  import frame_buffer_pkg::*;
#(
  parameter int w     = 128,
  parameter int DEPTH = FB_DEPTH
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [0:w-1] idata,
  input  logic         ivalid,
  output logic [0:w-1] odata,
  output logic         ovalid,
  output logic         olast,
  input  logic         iready,
  output logic         odrop
`ifdef FRAME_BUFFER_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_count
`endif
);
  localparam int AW = $clog2(DEPTH);

  ptr_t          r_wr, r_cm, r_rd;
  logic          r_ivalid_q, r_bad, r_ovalid, r_odrop;
  ptr_t          w_occ;
  logic          w_full, w_we, w_frame_end, w_commit, w_drop, w_load;
  logic [AW-1:0] w_faddr;

  // Occupancy is taken before any read this cycle, so full+read still overflows.
  assign w_occ       = occupancy(r_wr, r_rd);
  assign w_full      = (w_occ == ptr_t'(DEPTH));
  assign w_we        = ivalid && !r_bad && !w_full;
  assign w_frame_end = r_ivalid_q && !ivalid;
  assign w_commit    = w_frame_end && !r_bad;
  assign w_drop      = w_frame_end && r_bad;
  assign w_faddr     = r_wr[AW-1:0] - AW'(1);
  // Load the output stage when it is empty or being drained, and only from
  // committed words.
  assign w_load      = (!r_ovalid || iready) && (r_rd != r_cm);

  // Write pointer, commit boundary and bad-frame tracking.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr       <= '0;
      r_cm       <= '0;
      r_bad      <= 1'b0;
      r_ivalid_q <= 1'b0;
      r_odrop    <= 1'b0;
    end else begin
      r_ivalid_q <= ivalid;
      r_odrop    <= w_drop;
      if (w_drop)      r_wr <= r_cm;
      else if (w_we)   r_wr <= r_wr + 1'b1;
      if (w_commit)    r_cm <= r_wr;
      if (w_drop)                    r_bad <= 1'b0;
      else if (ivalid && w_full)     r_bad <= 1'b1;
    end
  end

  // Read pointer and output-valid flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd     <= '0;
      r_ovalid <= 1'b0;
    end else begin
      if (w_load) begin
        r_rd     <= r_rd + 1'b1;
        r_ovalid <= 1'b1;
      end else if (iready) begin
        r_ovalid <= 1'b0;
      end
    end
  end

  frame_buffer_ram #(
    .W     (w),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clock   (clock),
    .reset   (reset),
    .i_we    (w_we),
    .i_waddr (r_wr[AW-1:0]),
    .i_wdata (idata),
    .i_fset  (w_commit),
    .i_faddr (w_faddr),
    .i_re    (w_load),
    .i_raddr (r_rd[AW-1:0]),
    .o_rdata (odata),
    .o_rlast (olast)
  );

  assign ovalid = r_ovalid;
  assign odrop  = r_odrop;

`ifdef FRAME_BUFFER_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  // Saturating count of dropped frames, stepping with each odrop pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                 r_drop_cnt <= '0;
    else if (w_drop && (r_drop_cnt != '1))      r_drop_cnt <= r_drop_cnt + 1'b1;
  end

  assign drop_count = r_drop_cnt;
`endif
endmodule

// File: tb/tb_frame_buffer.sv
// tb_frame_buffer: randomized frames checked against a queue of committed
// words (frames longer than DEPTH never reach the queue).
module tb_frame_buffer;
  localparam int W     = 128;
  localparam int DEPTH = 64;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [0:W-1] idata = '0;
  logic         ivalid = 1'b0;
  logic [0:W-1] odata;
  logic         ovalid, olast, odrop;
  logic         iready = 1'b0;
`ifdef FRAME_BUFFER_DROP_CNT_EN
  logic [15:0]  drop_count;
`endif

  frame_buffer #(.w(W), .DEPTH(DEPTH)) dut (
    .clock  (clock),
    .reset  (reset),
    .idata  (idata),
    .ivalid (ivalid),
    .odata  (odata),
    .ovalid (ovalid),
    .olast  (olast),
    .iready (iready),
    .odrop  (odrop)
`ifdef FRAME_BUFFER_DROP_CNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 clock = ~clock;

  int           checks = 0;
  int           errors = 0;
  int           tot_wr = 0;
  bit           send_done = 0;
  logic [W:0]   exp_q[$];

  task automatic tick();
    @(posedge clock); #1;
  endtask

  function automatic logic [0:W-1] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive one frame plus its frame-end cycle; queue it if it can ever fit.
  task automatic send_frame(input int len);
    logic [W:0] fr[$];
    logic [0:W-1] d;
    logic l;
    for (int i = 0; i < len; i++) begin
      d = rnd_word();
      l = (i == len - 1);
      idata  = d;
      ivalid = 1'b1;
      fr.push_back({l, d});
      tick();
    end
    ivalid = 1'b0;
    tick();
    if (len <= DEPTH) begin
      foreach (fr[i]) exp_q.push_back(fr[i]);
      tot_wr += len;
    end
  endtask

  // Consume output words until send_done and queue empty; checks order,
  // last flags and stability under backpressure.
  task automatic receive(input int pct, input int budget, input int stall_at);
    logic [0:W-1] hd;
    logic hl;
    bit hv;
    int cyc;
    logic [W:0] e;
    hv = 0; cyc = 0; hd = '0; hl = 1'b0;
    iready = (int'($urandom_range(99)) < pct);
    while (!(send_done && exp_q.size() == 0) && cyc < budget) begin
      @(negedge clock);
      if (hv) begin
        checks++;
        if (ovalid !== 1'b1 || odata !== hd || olast !== hl) begin
          errors++;
          $display("FAIL hold: got v=%b last=%b d=%h, need v=1 last=%b d=%h", ovalid, olast, odata, hl, hd);
        end
      end
      hv = 0;
      if (ovalid && iready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got last=%b d=%h, need none", olast, odata);
        end else begin
          e = exp_q.pop_front();
          if ({olast, odata} !== e) begin
            errors++;
            $display("FAIL word: got last=%b d=%h, need last=%b d=%h", olast, odata, e[W], e[W-1:0]);
          end
        end
      end else if (ovalid) begin
        hv = 1; hd = odata; hl = olast;
      end
      @(posedge clock); #1;
      cyc++;
      if (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 10) iready = 1'b0;
      else iready = (int'($urandom_range(99)) < pct);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d words left, need 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    checks++;
    if ({ovalid, olast, odrop} !== 3'b000 || odata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b l=%b dr=%b d=%h, need all 0", ovalid, olast, odrop, odata);
    end
    reset = 1'b1;
    tick();
    exp_q.delete();
    tot_wr = 0;
  endtask

  task automatic test_single();
    logic [0:W-1] a, b, c;
    a = rnd_word(); b = rnd_word(); c = rnd_word();
    iready = 1'b1;
    idata = a; ivalid = 1'b1; tick();
    idata = b; tick();
    idata = c; tick();
    ivalid = 1'b0; tick();
    tot_wr += 3;
    checks++;
    if (ovalid !== 1'b0) begin errors++; $display("FAIL single_latency_E: got v=%b, need 0", ovalid); end
    tick();
    checks++;
    if ({ovalid, olast, odata} !== {2'b10, a}) begin errors++; $display("FAIL single_A: got v=%b l=%b d=%h, need v=1 l=0 d=%h", ovalid, olast, odata, a); end
    tick();
    checks++;
    if ({ovalid, olast, odata} !== {2'b10, b}) begin errors++; $display("FAIL single_B: got v=%b l=%b d=%h, need v=1 l=0 d=%h", ovalid, olast, odata, b); end
    tick();
    checks++;
    if ({ovalid, olast, odata} !== {2'b11, c}) begin errors++; $display("FAIL single_C: got v=%b l=%b d=%h, need v=1 l=1 d=%h", ovalid, olast, odata, c); end
    tick();
    checks++;
    if (ovalid !== 1'b0) begin errors++; $display("FAIL single_end: got v=%b, need 0", ovalid); end
  endtask

  // Two frames committed while held, then released: seven words, no gaps.
  task automatic test_back_to_back();
    logic [W:0] e;
    iready = 1'b0;
    send_frame(2);
    send_frame(5);
    iready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      checks++;
      if (ovalid !== 1'b1 || {olast, odata} !== e) begin
        errors++;
        $display("FAIL b2b_word%0d: got v=%b l=%b d=%h, need v=1 l=%b d=%h", i, ovalid, olast, odata, e[W], e[W-1:0]);
      end
    end
    @(negedge clock);
    checks++;
    if (ovalid !== 1'b0) begin errors++; $display("FAIL b2b_end: got v=%b, need 0", ovalid); end
    tick();
  endtask

  task automatic test_backpressure();
    iready = 1'b0;
    send_frame(6);
    send_done = 1;
    receive(100, 200, 2);
    tick();
  endtask

  task automatic test_overflow();
    logic [6:0] exp_wr;
    int tmp;
    iready = 1'b0;
    tmp = tot_wr;
    exp_wr = tmp[6:0];
    send_frame(70);
    checks++;
    if (odrop !== 1'b1 || ovalid !== 1'b0) begin errors++; $display("FAIL ovf_drop: got dr=%b v=%b, need dr=1 v=0", odrop, ovalid); end
    tick();
    checks++;
    if (odrop !== 1'b0 || ovalid !== 1'b0) begin errors++; $display("FAIL ovf_after: got dr=%b v=%b, need dr=0 v=0", odrop, ovalid); end
    checks++;
    if (dut.r_wr !== exp_wr) begin errors++; $display("FAIL ovf_wr: got %0d, need %0d", dut.r_wr, exp_wr); end
    iready = 1'b1;
    send_frame(4);
    send_done = 1;
    receive(100, 100, -1);
  endtask

  task automatic test_random();
    send_done = 0;
    fork
      begin
        int len, wt;
        for (int f = 0; f < 30; f++) begin
          len = (f % 5 == 4) ? int'($urandom_range(20, 9)) : int'($urandom_range(8, 1));
          wt = 0;
          while (exp_q.size() + len > DEPTH && wt < 1000) begin tick(); wt++; end
          send_frame(len);
          repeat ($urandom_range(2)) tick();
        end
        send_done = 1;
      end
      receive(60, 5000, -1);
    join
  endtask

  task automatic test_reset_mid();
    iready = 1'b0;
    send_done = 0;
    send_frame(3);
    for (int i = 0; i < 3; i++) begin idata = rnd_word(); ivalid = 1'b1; tick(); end
    checks++;
    if (ovalid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got v=%b, need 1", ovalid); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({ovalid, olast, odrop} !== 3'b000 || odata !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: got v=%b l=%b dr=%b d=%h, need all 0", ovalid, olast, odrop, odata);
    end
    ivalid = 1'b0;
    exp_q.delete();
    tot_wr = 0;
    tick(); tick();
    reset = 1'b1;
    iready = 1'b1;
    begin
      bit seen = 0;
      for (int i = 0; i < 10; i++) begin tick(); if (ovalid) seen = 1; end
      checks++;
      if (seen) begin errors++; $display("FAIL rstmid_quiet: got ovalid=1, need 0"); end
    end
    send_frame(2);
    send_done = 1;
    receive(100, 50, -1);
  endtask

`ifdef FRAME_BUFFER_DROP_CNT_EN
  task automatic test_drop_count();
    iready = 1'b1;
    for (int i = 0; i < 3; i++) send_frame(65 + i);
    tick();
    checks++;
    if (drop_count !== 16'd3) begin errors++; $display("FAIL drop_cnt: got %0d, need 3", drop_count); end
    force dut.r_drop_cnt = 16'hFFFF;
    tick();
    release dut.r_drop_cnt;
    send_frame(70);
    tick();
    checks++;
    if (drop_count !== 16'hFFFF) begin errors++; $display("FAIL drop_cnt_sat: got %h, need ffff", drop_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    send_done = 0;
    test_backpressure();
    send_done = 0;
    test_overflow();
    test_random();
    test_reset_mid();
`ifdef FRAME_BUFFER_DROP_CNT_EN
    test_drop_count();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
